// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss handler.
package cache_pkg;

  localparam int unsigned SIZE_BLOCK_DEF = 32;
  localparam int unsigned BIT_TOTAL_DEF  = 24;
  localparam int unsigned BIT_BYTE_DEF   = $clog2(SIZE_BLOCK_DEF / 8);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    RESP
  } cmh_state_t;

  // Word address to byte address: append bit_byte zero bits.
  function automatic logic [63:0] byte_addr(input logic [63:0] word_addr,
                                            input int unsigned bit_byte = BIT_BYTE_DEF);
    return word_addr << bit_byte;
  endfunction

endpackage

// File: rtl/cmh_sat_counter.sv
// Saturating up-counter used for the optional hit/miss statistics.
module cmh_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones, clear on rst or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_miss_handler.sv
// Requester-side controller for cache_ro: looks up a single-word read,
// refills from SDRAM over Avalon-MM on a miss, then returns the word.
// Optional feature macro: CACHE_MISS_HANDLER_STATS_EN adds saturating
// hit/miss counters on ports stat_hits / stat_misses.
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int unsigned SIZE_BLOCK = SIZE_BLOCK_DEF,
  parameter int unsigned BIT_TOTAL  = BIT_TOTAL_DEF
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic [BIT_TOTAL-1:0]                        req_addr,
  output logic                                        rsp_valid,
  input  logic                                        rsp_ready,
  output logic [SIZE_BLOCK-1:0]                       rsp_data,
  output logic                                        rsp_hit,
  output logic                                        c_en,
  output logic                                        c_wrt,
  output logic [BIT_TOTAL-1:0]                        c_addr,
  output logic [SIZE_BLOCK-1:0]                       c_wdata,
  input  logic [SIZE_BLOCK-1:0]                       c_rdata,
  input  logic                                        c_success,
  output logic                                        avm_read,
  output logic [BIT_TOTAL+$clog2(SIZE_BLOCK/8)-1:0]   avm_address,
  input  logic                                        avm_waitrequest,
  input  logic [SIZE_BLOCK-1:0]                       avm_readdata,
  input  logic                                        avm_readdatavalid
`ifdef CACHE_MISS_HANDLER_STATS_EN
  ,
  output logic [31:0]                                 stat_hits,
  output logic [31:0]                                 stat_misses
`endif
);

  localparam int unsigned BIT_BYTE = $clog2(SIZE_BLOCK / 8);
  localparam int unsigned AVM_W    = BIT_TOTAL + BIT_BYTE;

  cmh_state_t           state;
  logic [BIT_TOTAL-1:0] addr_q;

  // Request FSM; every output is a register updated on the transition into
  // the state that owns it, so it is valid for the whole of that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_hit     <= 1'b0;
      c_en        <= 1'b0;
      c_wrt       <= 1'b0;
      c_addr      <= '0;
      c_wdata     <= '0;
      avm_read    <= 1'b0;
      avm_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            c_en      <= 1'b1;
            c_wrt     <= 1'b0;
            c_addr    <= req_addr;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          c_en  <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          if (c_success) begin
            rsp_data  <= c_rdata;
            rsp_hit   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            avm_read    <= 1'b1;
            avm_address <= AVM_W'(byte_addr(64'(addr_q), BIT_BYTE));
            state       <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            // Data may already be returning in the accept cycle.
            if (avm_readdatavalid) begin
              c_en    <= 1'b1;
              c_wrt   <= 1'b1;
              c_addr  <= addr_q;
              c_wdata <= avm_readdata;
              state   <= FILL;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (avm_readdatavalid) begin
            c_en    <= 1'b1;
            c_wrt   <= 1'b1;
            c_addr  <= addr_q;
            c_wdata <= avm_readdata;
            state   <= FILL;
          end
        end
        FILL: begin
          c_en      <= 1'b0;
          c_wrt     <= 1'b0;
          rsp_data  <= c_wdata;
          rsp_hit   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_MISS_HANDLER_STATS_EN
  logic check_hit;
  logic check_miss;

  assign check_hit  = (state == CHECK) && c_success;
  assign check_miss = (state == CHECK) && !c_success;

  cmh_sat_counter #(.WIDTH(32)) u_stat_hits (
    .clk   (clk),
    .rst   (rst),
    .inc   (check_hit),
    .clear (1'b0),
    .count (stat_hits)
  );

  cmh_sat_counter #(.WIDTH(32)) u_stat_misses (
    .clk   (clk),
    .rst   (rst),
    .inc   (check_miss),
    .clear (1'b0),
    .count (stat_misses)
  );
`endif

endmodule

// File: tb/tb_cache_miss_handler.sv
// Bench for cache_miss_handler with a direct-mapped cache model and an
// Avalon memory model (mem[a] = a ^ 32'hA5A5_0000).
module tb_cache_miss_handler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_rst;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_hit;
  logic        c_en;
  logic        c_wrt;
  logic [23:0] c_addr;
  logic [31:0] c_wdata;
  logic [31:0] c_rdata = '0;
  logic        c_success = 1'b0;
  logic        avm_read;
  logic [25:0] avm_address;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
`ifdef CACHE_MISS_HANDLER_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  always #5 clk = ~clk;

  cache_miss_handler #(.SIZE_BLOCK(32), .BIT_TOTAL(24)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .rsp_hit           (rsp_hit),
    .c_en              (c_en),
    .c_wrt             (c_wrt),
    .c_addr            (c_addr),
    .c_wdata           (c_wdata),
    .c_rdata           (c_rdata),
    .c_success         (c_success),
    .avm_read          (avm_read),
    .avm_address       (avm_address),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
`ifdef CACHE_MISS_HANDLER_STATS_EN
    ,
    .stat_hits         (stat_hits),
    .stat_misses       (stat_misses)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    return {8'h00, a} ^ 32'hA5A5_0000;
  endfunction

  // Cache model: 256-entry direct-mapped, index addr[7:0], tag addr[23:8].
  logic [31:0] cdata [256];
  logic [15:0] ctag  [256];
  logic        cval  [256];

  always @(posedge clk) begin
    if (cache_rst) begin
      for (int i = 0; i < 256; i++) cval[i] <= 1'b0;
    end else if (c_en) begin
      if (c_wrt) begin
        cdata[c_addr[7:0]] <= c_wdata;
        ctag[c_addr[7:0]]  <= c_addr[23:8];
        cval[c_addr[7:0]]  <= 1'b1;
      end else begin
        c_rdata   <= cdata[c_addr[7:0]];
        c_success <= cval[c_addr[7:0]] && (ctag[c_addr[7:0]] == c_addr[23:8]);
      end
    end
  end

  // Avalon memory model: cfg_stall waitrequest cycles, readdatavalid cfg_lat
  // cycles after the accept edge. Not reset by the DUT reset.
  int          cfg_stall = 0;
  int          cfg_lat   = 1;
  int          stall_left = 0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;

  assign avm_waitrequest = avm_read && (stall_left != 0);

  always @(posedge clk) begin
    avm_readdatavalid <= 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        avm_readdatavalid <= 1'b1;
        avm_readdata      <= pend_data;
        pend              <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
    if (!avm_read) begin
      stall_left <= cfg_stall;
    end else if (stall_left != 0) begin
      stall_left <= stall_left - 1;
    end else if (cfg_lat <= 1) begin
      avm_readdatavalid <= 1'b1;
      avm_readdata      <= mem_word(avm_address[25:2]);
    end else begin
      pend      <= 1'b1;
      pend_cnt  <= cfg_lat - 1;
      pend_data <= mem_word(avm_address[25:2]);
    end
  end

  // Observation counters and the response scoreboard.
  int          rd_cycles = 0, wrt_pulses = 0, lookups = 0, ready_cycles = 0, addr_unstable = 0;
  logic [25:0] last_avm_addr = '0, prev_addr = '0;
  logic        prev_rd = 1'b0;
  logic [23:0] last_wrt_addr = '0;
  logic [31:0] last_wrt_data = '0;

  always @(negedge clk) begin
    exp_t e;
    if (avm_read) begin
      rd_cycles++;
      if (prev_rd && (avm_address !== prev_addr)) addr_unstable++;
      last_avm_addr = avm_address;
    end
    prev_rd   = avm_read;
    prev_addr = avm_address;
    if (c_en && c_wrt) begin
      wrt_pulses++;
      last_wrt_addr = c_addr;
      last_wrt_data = c_wdata;
    end
    if (c_en && !c_wrt) lookups++;
    if (req_ready) ready_cycles++;
    if (rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data=%h hit=%b, expected no response", rsp_data, rsp_hit);
      end else begin
        e = exp_q.pop_front();
        if ((rsp_data !== e.data) || (rsp_hit !== e.hit)) begin
          errors++;
          $display("FAIL sb_rsp: got data=%h hit=%b, expected data=%h hit=%b",
                   rsp_data, rsp_hit, e.data, e.hit);
        end
      end
    end
  end

  // Issue one request, push its expectation, return edges from accept to rsp_valid (-1 on timeout).
  task automatic send(input logic [23:0] a, input logic [31:0] ed, input logic eh, output int lat);
    int n;
    exp_q.push_back({eh, ed});
    req_addr  = a;
    req_valid = 1'b1;
    lat = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        break;
      end
      @(posedge clk); #2;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cache_rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({rsp_valid, rsp_hit, c_en, c_wrt, avm_read, rsp_data, c_addr, c_wdata, avm_address} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b h=%b en=%b wrt=%b rd=%b d=%h ca=%h wd=%h aa=%h, expected all 0",
               rsp_valid, rsp_hit, c_en, c_wrt, avm_read, rsp_data, c_addr, c_wdata, avm_address);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    rst = 1'b0; cache_rst = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_cold_miss();
    int lat, w0, r0;
    w0 = wrt_pulses; r0 = rd_cycles;
    send(24'h000003, 32'hA5A5_0003, 1'b0, lat);
    @(posedge clk); #2;
    checks++;
    if (lat != 6) begin errors++; $display("FAIL cold_latency: got %0d expected 6", lat); end
    checks++;
    if (last_avm_addr !== 26'h000000C) begin errors++; $display("FAIL cold_avm_address: got %h expected 00000c", last_avm_addr); end
    checks++;
    if (rd_cycles - r0 != 1) begin errors++; $display("FAIL cold_read_cycles: got %0d expected 1", rd_cycles - r0); end
    checks++;
    if (wrt_pulses - w0 != 1) begin errors++; $display("FAIL cold_fill_pulses: got %0d expected 1", wrt_pulses - w0); end
    checks++;
    if ((last_wrt_addr !== 24'h000003) || (last_wrt_data !== 32'hA5A5_0003)) begin
      errors++;
      $display("FAIL cold_fill_write: got addr=%h data=%h expected addr=000003 data=a5a50003", last_wrt_addr, last_wrt_data);
    end
  endtask

  task automatic test_hit_latency();
    int lat, r0, w0;
    r0 = rd_cycles; w0 = wrt_pulses;
    send(24'h000003, 32'hA5A5_0003, 1'b1, lat);
    @(posedge clk); #2;
    checks++;
    if (lat != 3) begin errors++; $display("FAIL hit_latency: got %0d expected 3", lat); end
    checks++;
    if ((rd_cycles != r0) || (wrt_pulses != w0)) begin
      errors++;
      $display("FAIL hit_no_memory: got reads=%0d fills=%0d expected 0 0", rd_cycles - r0, wrt_pulses - w0);
    end
  endtask

  task automatic test_alias();
    int lat1, lat2, w0;
    w0 = wrt_pulses;
    send(24'h000103, 32'hA5A5_0103, 1'b0, lat1);
    @(posedge clk); #2;
    send(24'h000003, 32'hA5A5_0003, 1'b0, lat2);
    @(posedge clk); #2;
    checks++;
    if ((lat1 != 6) || (lat2 != 6)) begin errors++; $display("FAIL alias_latency: got %0d,%0d expected 6,6", lat1, lat2); end
    checks++;
    if (wrt_pulses - w0 != 2) begin errors++; $display("FAIL alias_fills: got %0d expected 2", wrt_pulses - w0); end
  endtask

  task automatic test_stall();
    int lat, r0, u0, rdy0;
    cfg_stall = 5; cfg_lat = 3;
    r0 = rd_cycles; u0 = addr_unstable; rdy0 = ready_cycles;
    send(24'h000020, mem_word(24'h000020), 1'b0, lat);
    @(posedge clk); #2;
    cfg_stall = 0; cfg_lat = 1;
    checks++;
    if (lat != 13) begin errors++; $display("FAIL stall_latency: got %0d expected 13", lat); end
    checks++;
    if (rd_cycles - r0 != 6) begin errors++; $display("FAIL stall_read_cycles: got %0d expected 6", rd_cycles - r0); end
    checks++;
    if (addr_unstable != u0) begin errors++; $display("FAIL stall_addr_stable: got %0d changes expected 0", addr_unstable - u0); end
    checks++;
    if (last_avm_addr !== 26'h0000080) begin errors++; $display("FAIL stall_avm_address: got %h expected 000080", last_avm_addr); end
    checks++;
    if (ready_cycles - rdy0 != 1) begin errors++; $display("FAIL stall_req_ready: got %0d ready cycles expected 1", ready_cycles - rdy0); end
  endtask

  task automatic test_backpressure();
    int lat, l0;
    rsp_ready = 1'b0;
    l0 = lookups;
    send(24'h000003, 32'hA5A5_0003, 1'b1, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL bp_latency: got %0d expected 3", lat); end
    @(posedge clk); #2;
    req_addr = 24'h000007; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ((rsp_valid !== 1'b1) || (rsp_data !== 32'hA5A5_0003) || (rsp_hit !== 1'b1) || (req_ready !== 1'b0)) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h h=%b rdy=%b expected v=1 d=a5a50003 h=1 rdy=0",
                 i, rsp_valid, rsp_data, rsp_hit, req_ready);
      end
      @(posedge clk); #2;
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #2;
    checks++;
    if ((rsp_valid !== 1'b0) || (req_ready !== 1'b1)) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=1", rsp_valid, req_ready);
    end
    checks++;
    if (lookups - l0 != 1) begin errors++; $display("FAIL bp_no_accept: got %0d lookups expected 1", lookups - l0); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] addrs [4];
    int acc [4];
    int k, cyc;
    addrs = '{24'h000003, 24'h000020, 24'h000003, 24'h000020};
    k = 0; cyc = 0;
    rsp_ready = 1'b1;
    req_addr = addrs[0]; req_valid = 1'b1;
    for (int i = 0; i < 60 && k < 4; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc[k] = cyc;
        exp_q.push_back({1'b1, mem_word(addrs[k])});
        k++;
      end
      @(posedge clk); #2;
      cyc++;
      if (k < 4) req_addr = addrs[k];
      else req_valid = 1'b0;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || rsp_valid); i++) begin
      @(posedge clk); #2;
    end
    checks++;
    if (k != 4) begin errors++; $display("FAIL b2b_accepts: got %0d expected 4", k); end
    for (int i = 1; i < 4 && i < k; i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 4) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 4", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat, l0, w0;
    logic found;
`ifdef CACHE_MISS_HANDLER_STATS_EN
    checks++;
    if ((stat_hits !== 32'd6) || (stat_misses !== 32'd4)) begin
      errors++;
      $display("FAIL stats_before_reset: got hits=%0d misses=%0d expected 6 4", stat_hits, stat_misses);
    end
`endif
    cfg_lat = 6;
    req_addr = 24'h000009; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (avm_read && !avm_waitrequest) begin found = 1'b1; break; end
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    checks++;
    if (!found) begin errors++; $display("FAIL abort_reach_mem: got no avm read accept expected one"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_hit, c_en, c_wrt, avm_read, rsp_data, c_addr, c_wdata, avm_address} !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_outputs: got v=%b en=%b rd=%b ca=%h aa=%h rdy=%b expected all 0 rdy=1",
               rsp_valid, c_en, avm_read, c_addr, avm_address, req_ready);
    end
    @(posedge clk); #2;
    rst = 1'b0; cfg_lat = 1;
    l0 = lookups; w0 = wrt_pulses;
    repeat (8) @(posedge clk);
    #2;
    checks++;
    if ((lookups != l0) || (wrt_pulses != w0) || (rsp_valid !== 1'b0) || (req_ready !== 1'b1)) begin
      errors++;
      $display("FAIL stray_beat: got lookups=%0d fills=%0d v=%b rdy=%b expected 0 0 0 1",
               lookups - l0, wrt_pulses - w0, rsp_valid, req_ready);
    end
`ifdef CACHE_MISS_HANDLER_STATS_EN
    checks++;
    if ((stat_hits !== 32'd0) || (stat_misses !== 32'd0)) begin
      errors++;
      $display("FAIL stats_cleared: got hits=%0d misses=%0d expected 0 0", stat_hits, stat_misses);
    end
`endif
    send(24'h000005, 32'hA5A5_0005, 1'b0, lat);
    @(posedge clk); #2;
    checks++;
    if (lat != 6) begin errors++; $display("FAIL after_reset_latency: got %0d expected 6", lat); end
`ifdef CACHE_MISS_HANDLER_STATS_EN
    checks++;
    if ((stat_hits !== 32'd0) || (stat_misses !== 32'd1)) begin
      errors++;
      $display("FAIL stats_after_reset: got hits=%0d misses=%0d expected 0 1", stat_hits, stat_misses);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_latency();
    test_alias();
    test_stall();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: got %0d pending responses expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
